// File: rtl/uart_rx_x8.sv
// uart_rx_x8: 8x oversampling UART receiver with a valid/ready output port.
// Synchronizes rx, qualifies the start bit at its midpoint, samples each bit
// once at mid-bit, checks optional parity and the stop bit, and holds each
// character until the consumer accepts it.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   bclk_x8        8x baud square wave, same clock domain as clk
//   rx             asynchronous serial line, idle high
//   rx_ready       consumer accepts the held character
//   rx_data        received character, right-aligned
//   rx_valid       rx_data / frame_err / parity_err are valid
//   frame_err      stop bit sampled low (qualified by rx_valid)
//   parity_err     parity mismatch (qualified by rx_valid)
//   overrun        one-cycle pulse when a completed frame is dropped
//   busy           receiver is not idle
module uart_rx_x8 #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bclk_x8,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic                   rx_m;
    logic                   rx_s;
    logic                   bclk_d;
    logic                   tick;
    logic [2:0]             tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic                   perr;

    assign tick = bclk_x8 & ~bclk_d;

    // Parity error folds the odd/even selection into the XOR so a matching
    // frame always yields 0.
    always_comb begin
        perr = 1'b0;
        if (PARITY_EN != 0)
            perr = (^shreg) ^ par_bit ^ (PARITY_ODD != 0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            bclk_d     <= 1'b0;
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            bclk_d  <= bclk_x8;
            overrun <= 1'b0;

            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    START: begin
                        tick_cnt <= tick_cnt + 3'd1;
                        // Start bit midpoint: still low means a real frame.
                        if (tick_cnt == 3'd3) begin
                            if (!rx_s) begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        tick_cnt <= tick_cnt + 3'd1;
                        if (tick_cnt == 3'd7) begin
                            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + BIT_ONE;
                            if (bit_cnt == BIT_LAST)
                                state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        tick_cnt <= tick_cnt + 3'd1;
                        if (tick_cnt == 3'd7) begin
                            par_bit <= rx_s;
                            state   <= STOP;
                        end
                    end
                    STOP: begin
                        tick_cnt <= tick_cnt + 3'd1;
                        if (tick_cnt == 3'd7) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            // A slot frees up if the held character is
                            // accepted in this same cycle.
                            if (!rx_valid || rx_ready) begin
                                rx_data    <= shreg;
                                frame_err  <= ~rx_s;
                                parity_err <= perr;
                                rx_valid   <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_x8.sv
// tb_uart_rx_x8: self-checking bench for uart_rx_x8.
// Drives frames aligned to bclk_x8 and checks against an expectation queue.
module tb_uart_rx_x8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bclk = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;

    logic [7:0] d_data;
    logic       d_valid, d_fe, d_pe, d_ovr, d_busy;
    logic [7:0] p_data;
    logic       p_valid, p_fe, p_pe, p_ovr, p_busy;

    int checks = 0;
    int errors = 0;

    int tp = 10;
    int ph = 0;

    int ovr_cnt = 0;
    int busy_cnt = 0;
    int fall_cnt = 0;
    int rise_cnt = 0;
    logic v_prev = 1'b0;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t q[$];

    uart_rx_x8 u_dut (
        .clk(clk), .rst_n(rst_n), .bclk_x8(bclk), .rx(rx),
        .rx_ready(rx_ready), .rx_data(d_data), .rx_valid(d_valid),
        .frame_err(d_fe), .parity_err(d_pe), .overrun(d_ovr),
        .busy(d_busy)
    );

    uart_rx_x8 #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .rst_n(rst_n), .bclk_x8(bclk), .rx(rx),
        .rx_ready(rx_ready), .rx_data(p_data), .rx_valid(p_valid),
        .frame_err(p_fe), .parity_err(p_pe), .overrun(p_ovr),
        .busy(p_busy)
    );

    always #5 clk = ~clk;

    // Baud generator model: tp clocks per tick, rising edge at ph==0.
    always @(negedge clk) begin
        if (ph >= tp - 1) ph = 0;
        else ph = ph + 1;
        bclk = (ph < tp / 2);
    end

    always @(negedge clk) begin
        if (d_ovr) ovr_cnt = ovr_cnt + 1;
        if (d_busy) busy_cnt = busy_cnt + 1;
        if (v_prev && !d_valid) fall_cnt = fall_cnt + 1;
        if (!v_prev && d_valid) rise_cnt = rise_cnt + 1;
        v_prev = d_valid;
    end

    // Returns on the negedge where bclk rises, so the next posedge is a tick.
    task automatic align();
        do @(posedge clk); while (ph != tp - 1);
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (8 * tp) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit use_par,
                              input logic par, input logic stop);
        exp_t e;
        e.d  = d;
        e.fe = ~stop;
        e.pe = use_par ? ((^d) ^ par) : 1'b0;
        q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (use_par) drive_bit(par);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic apply_reset();
        rx = 1'b1;
        rx_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        q.delete();
    endtask

    task automatic test_reset();
        int b0;
        rst_n = 1'b0;
        rx = 1'b0;
        rx_ready = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if ({d_valid, d_fe, d_pe, d_ovr, d_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {d_valid, d_fe, d_pe, d_ovr, d_busy});
        end
        checks++;
        if (d_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00", d_data);
        end
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        b0 = busy_cnt;
        repeat (20 * tp) @(negedge clk);
        checks++;
        if (busy_cnt != b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %0d busy cycles expected 0",
                     busy_cnt - b0);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        tp = 109;
        align();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        e = q.pop_front();
        checks++;
        if (d_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_valid: got %b expected 1", d_valid);
        end
        checks++;
        if (d_data !== e.d) begin
            errors++;
            $display("FAIL basic_data: got %h expected %h", d_data, e.d);
        end
        checks++;
        if ({d_fe, d_pe} !== {e.fe, e.pe}) begin
            errors++;
            $display("FAIL basic_flags: got %b expected %b",
                     {d_fe, d_pe}, {e.fe, e.pe});
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++;
        if (d_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_consume: got %b expected 0", d_valid);
        end
        checks++;
        if (d_data !== 8'hA5) begin
            errors++;
            $display("FAIL basic_hold: got %h expected a5", d_data);
        end
    endtask

    task automatic test_glitch();
        int b0, r0;
        tp = 10;
        b0 = busy_cnt;
        r0 = rise_cnt;
        align();
        rx = 1'b0;
        repeat (2 * tp) @(negedge clk);
        rx = 1'b1;
        repeat (12 * tp) @(negedge clk);
        checks++;
        if (busy_cnt == b0) begin
            errors++;
            $display("FAIL glitch_seen: got 0 busy cycles expected >0");
        end
        checks++;
        if (d_busy !== 1'b0 || rise_cnt != r0) begin
            errors++;
            $display("FAIL glitch_reject: got busy=%b valids=%0d expected 0 0",
                     d_busy, rise_cnt - r0);
        end
    endtask

    task automatic test_frame_err();
        exp_t e;
        align();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        e = q.pop_front();
        checks++;
        if (d_valid !== 1'b1 || d_data !== e.d) begin
            errors++;
            $display("FAIL ferr_data: got v=%b %h expected v=1 %h",
                     d_valid, d_data, e.d);
        end
        checks++;
        if ({d_fe, d_pe} !== {e.fe, e.pe}) begin
            errors++;
            $display("FAIL ferr_flags: got %b expected %b",
                     {d_fe, d_pe}, {e.fe, e.pe});
        end
        repeat (16 * tp) @(negedge clk);
        checks++;
        if (d_busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_idle: got busy=%b expected 0", d_busy);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_parity();
        exp_t e;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            align();
            send_frame(8'h07, 1'b1, (k == 0), 1'b1);
            e = q.pop_front();
            checks++;
            if (p_valid !== 1'b1 || p_data !== e.d) begin
                errors++;
                $display("FAIL parity_data%0d: got v=%b %h expected v=1 %h",
                         k, p_valid, p_data, e.d);
            end
            checks++;
            if ({p_fe, p_pe} !== {e.fe, e.pe}) begin
                errors++;
                $display("FAIL parity_flags%0d: got %b expected %b",
                         k, {p_fe, p_pe}, {e.fe, e.pe});
            end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            repeat (8 * tp) @(negedge clk);
        end
    endtask

    task automatic test_overrun();
        exp_t e1, e2;
        int o0;
        apply_reset();
        o0 = ovr_cnt;
        align();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        repeat (tp) @(negedge clk);
        e1 = q.pop_front();
        e2 = q.pop_front();
        checks++;
        if (d_valid !== 1'b1 || d_data !== e1.d) begin
            errors++;
            $display("FAIL ovr_hold: got v=%b %h expected v=1 %h (dropped %h)",
                     d_valid, d_data, e1.d, e2.d);
        end
        checks++;
        if (ovr_cnt - o0 != 1) begin
            errors++;
            $display("FAIL ovr_pulse: got %0d cycles expected 1",
                     ovr_cnt - o0);
        end
        checks++;
        if ({d_fe, d_pe} !== {e1.fe, e1.pe}) begin
            errors++;
            $display("FAIL ovr_flags: got %b expected %b",
                     {d_fe, d_pe}, {e1.fe, e1.pe});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2;
        int o0, f0;
        apply_reset();
        o0 = ovr_cnt;
        f0 = fall_cnt;
        align();
        fork
            begin
                send_frame(8'h11, 1'b0, 1'b0, 1'b1);
                send_frame(8'h22, 1'b0, 1'b0, 1'b1);
            end
            begin
                // Second frame's stop sample lands 157 ticks after the
                // aligned start edge.
                repeat (157 * tp) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        repeat (tp) @(negedge clk);
        e1 = q.pop_front();
        e2 = q.pop_front();
        checks++;
        if (d_valid !== 1'b1 || d_data !== e2.d) begin
            errors++;
            $display("FAIL b2b_data: got v=%b %h expected v=1 %h (after %h)",
                     d_valid, d_data, e2.d, e1.d);
        end
        checks++;
        if (ovr_cnt != o0 || fall_cnt != f0) begin
            errors++;
            $display("FAIL b2b_cont: got ovr=%0d drops=%0d expected 0 0",
                     ovr_cnt - o0, fall_cnt - f0);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        apply_reset();
        align();
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        e = q.pop_front();
        checks++;
        if (d_valid !== 1'b1 || d_data !== e.d) begin
            errors++;
            $display("FAIL mid_pre: got v=%b %h expected v=1 %h",
                     d_valid, d_data, e.d);
        end
        align();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d_valid, d_busy, d_fe, d_ovr} !== 4'b0 || d_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_clear: got %b %h expected 0000 00",
                     {d_valid, d_busy, d_fe, d_ovr}, d_data);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (16 * tp) @(negedge clk);
        align();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        e = q.pop_front();
        checks++;
        if (d_valid !== 1'b1 || d_data !== e.d) begin
            errors++;
            $display("FAIL mid_next: got v=%b %h expected v=1 %h",
                     d_valid, d_data, e.d);
        end
        checks++;
        if ({d_fe, d_pe} !== {e.fe, e.pe}) begin
            errors++;
            $display("FAIL mid_flags: got %b expected %b",
                     {d_fe, d_pe}, {e.fe, e.pe});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_parity();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_x8.md
# uart_rx_x8

Oversampling UART receiver: the receive-side consumer of the baud generator's `bclk_x8` output. Synchronizes the asynchronous serial line, validates the start bit, samples each bit once at mid-bit using 8 ticks per bit, checks optional parity and the stop bit, and presents each received character on a valid/ready interface. It sits between the board RX pin and the host-side command/data logic.

## Interface
- `DATA_BITS`, 8, data bits per frame (5–8), sent LSB first
- `PARITY_EN`, 0, 1 = a parity bit follows the data bits
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even parity; ignored when `PARITY_EN`=0

- `clk` in 1: system clock, 100 MHz
- `rst_n` in 1: reset, asynchronous, active-low
- `bclk_x8` in 1: 8x baud square wave from the baud generator, same clock domain
- `rx` in 1: serial line, asynchronous, idle high
- `rx_ready` in 1: consumer accepts the current character
- `rx_data` out `DATA_BITS`: received character, right-aligned
- `rx_valid` out 1: `rx_data` and the error flags are valid
- `frame_err` out 1: stop bit sampled low; qualified by `rx_valid`
- `parity_err` out 1: parity mismatch; qualified by `rx_valid`; always 0 when `PARITY_EN`=0
- `overrun` out 1: one-cycle pulse when a completed frame is dropped
- `busy` out 1: high in every state except IDLE

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- `tick` = rising edge of `bclk_x8`: `bclk_x8` & ~`bclk_x8_d`, with `bclk_x8_d` reset to 0. All FSM activity advances only on `tick`.
- FSM states: IDLE, START, DATA, PARITY, STOP. Counters: `tick_cnt` is 3 bits; `bit_cnt` is wide enough to hold `DATA_BITS`.
- IDLE: on a tick with `rx_s`=0, go to START with `tick_cnt`=0.
- START: each tick increments `tick_cnt`. On the tick where `tick_cnt`==3, check `rx_s`:
  - `rx_s`=0: go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
  - `rx_s`=1: go to IDLE. This is a glitch rejection and produces no output.
- DATA: each tick increments `tick_cnt`. On the tick where `tick_cnt`==7, shift `rx_s` into the MSB of the shift register (right shift) and increment `bit_cnt`. After `DATA_BITS` samples, go to PARITY if `PARITY_EN`=1, else go to STOP.
- PARITY: at `tick_cnt`==7, sample the parity bit. A mismatch is when XOR of the data bits ^ the parity bit ^ `PARITY_ODD` is 1.
- STOP: at `tick_cnt`==7, sample the stop bit and set `frame_err` = ~`rx_s`. Then go to IDLE regardless of the result. A character with a frame error is still delivered.
- Delivery, on the STOP-sample tick:
  - If `rx_valid`=0, or `rx_valid`=1 with `rx_ready`=1 in the same cycle: load `rx_data`, `frame_err` and `parity_err`, and set `rx_valid`=1.
  - Otherwise, drop the new frame. The held data and flags are unchanged, and `overrun` pulses for 1 cycle.
- Handshake: `rx_valid`=1 with `rx_ready`=1 at a clock edge clears `rx_valid` next cycle, unless a new frame is delivered in that same cycle. `rx_data` keeps its value after it is consumed.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0
  - state IDLE, all counters 0
- A reset asserted mid-frame aborts the frame immediately (asynchronously). After release, reception restarts from IDLE, and a line still low is treated as a new start candidate.
- `rx_valid` rises 1 clk after the STOP-sample tick edge. Data bit n is sampled 4+8·(n+1) ticks after start detection, which is mid-bit.
- Frame-to-frame: a start bit that begins immediately after the stop bit is detected. Back-to-back frames require no idle time.
- Changing the `bclk_x8` rate mid-frame is unsupported. The block must still return to IDLE within one frame time.
- A tick cannot occur on consecutive clocks, because each `bclk_x8` half-period is at least 2 clk.

## Test plan
- Reset: hold `rst_n`=0 with `rx`=0 → all outputs 0; after release with `rx`=1, `busy` stays 0.
- Basic receive: 115200 baud (tick every 109 clk), send 0xA5 with a valid stop bit, `rx_ready`=0 → `rx_valid`=1, `rx_data`=0xA5, `frame_err`=0, `parity_err`=0. Then pulse `rx_ready` → `rx_valid`=0 next clk.
- Glitch and frame error:
  - Low pulse of 2 ticks on an idle line → `busy` returns to 0 with no `rx_valid`.
  - Send 0x3C with stop bit = 0 → `rx_data`=0x3C, `frame_err`=1.
- Parity: `PARITY_EN`=1, `PARITY_ODD`=0, send 0x07.
  - Parity bit 1 → `parity_err`=0.
  - Parity bit 0 → `parity_err`=1.
- Overrun: send 0x11 then 0x22 back-to-back with `rx_ready`=0 → `rx_data`=0x11 is retained, `overrun` pulses once at the second STOP sample.
- Simultaneous accept: `rx_ready`=1 exactly on the second frame's STOP-sample tick → `rx_data`=0x22, `rx_valid` stays 1, no `overrun`. Also assert reset mid-DATA → outputs clear and the next clean frame 0x5A is received correctly.
